// File: rtl/reg32_ser_pkg.sv
// Shared constants and state encoding for the reg32_serializer transmitter.
// Optional parity stage is enabled with SERIALIZER_PARITY_EN.
package reg32_ser_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

  typedef logic [1:0] ser_state_t;

  localparam ser_state_t ST_IDLE  = 2'd0;
  localparam ser_state_t ST_SHIFT = 2'd1;
  localparam ser_state_t ST_FIN   = 2'd2;
  localparam ser_state_t ST_PAR   = 2'd3;

endpackage

// File: rtl/reg32_serializer_ser_bit_counter.sv
// Clearable, enabled up-counter with a terminal-count flag at WIDTH-1.
// Saturates at the terminal count so it can never wrap.
module ser_bit_counter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] count_q, count_d;

  assign tc_o = (count_q == CNT_W'(WIDTH - 1));

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !tc_o) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/reg32_serializer.sv
// Parallel-to-serial transmitter: loads a word on valid/ready, shifts it out MSB first.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after the data bits.
module reg32_serializer
  import reg32_ser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic [WIDTH-1:0] data_in_i,
  input  logic             ser_ready_i,
  output logic             ser_valid_o,
  output logic             ser_out_o,
  output logic             busy_o,
  output logic             done_o
);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             load_fire;
  logic             shift_fire;
  logic             last_bit;

  assign load_fire  = (state_q == ST_IDLE) && load_valid_i;
  assign shift_fire = (state_q == ST_SHIFT) && ser_ready_i;

  ser_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (load_fire),
    .en_i   (shift_fire),
    .tc_o   (last_bit)
  );

`ifdef SERIALIZER_PARITY_EN
  logic par_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par_q <= 1'b0;
    end else if (load_fire) begin
      par_q <= ^data_in_i;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    case (state_q)
      ST_IDLE: begin
        if (load_valid_i) begin
          shreg_d = data_in_i;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ser_ready_i) begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
`ifdef SERIALIZER_PARITY_EN
          if (last_bit) state_d = ST_PAR;
`else
          if (last_bit) state_d = ST_FIN;
`endif
        end
      end
`ifdef SERIALIZER_PARITY_EN
      ST_PAR: begin
        if (ser_ready_i) state_d = ST_FIN;
      end
`endif
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  // All outputs decode from registers only, so there is no input-to-output path.
  assign load_ready_o = (state_q == ST_IDLE);
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_FIN);

`ifdef SERIALIZER_PARITY_EN
  assign ser_valid_o = (state_q == ST_SHIFT) || (state_q == ST_PAR);
  assign ser_out_o   = (state_q == ST_SHIFT) ? shreg_q[WIDTH-1] :
                       (state_q == ST_PAR)   ? par_q : 1'b0;
`else
  assign ser_valid_o = (state_q == ST_SHIFT);
  assign ser_out_o   = (state_q == ST_SHIFT) ? shreg_q[WIDTH-1] : 1'b0;
`endif

endmodule

// File: tb/tb_reg32_serializer.sv
// Randomized bench for reg32_serializer against a bit-queue reference model.
// Honors SERIALIZER_PARITY_EN the same way as the design.
module tb_reg32_serializer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        load_valid_i = 1'b0;
  logic        load_ready_o;
  logic [31:0] data_in_i = '0;
  logic        ser_ready_i = 1'b0;
  logic        ser_valid_o;
  logic        ser_out_o;
  logic        busy_o;
  logic        done_o;

  int n_pass = 0;
  int n_total = 0;

  reg32_serializer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .data_in_i    (data_in_i),
    .ser_ready_i  (ser_ready_i),
    .ser_valid_o  (ser_valid_o),
    .ser_out_o    (ser_out_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_load_ready"}, 32'(load_ready_o), 32'd1);
    chk({tag, "_ser_valid"},  32'(ser_valid_o),  32'd0);
    chk({tag, "_ser_out"},    32'(ser_out_o),    32'd0);
    chk({tag, "_busy"},       32'(busy_o),       32'd0);
    chk({tag, "_done"},       32'(done_o),       32'd0);
  endtask

  // mode 0: ready always high, 1: toggles starting high, 2: random
  task automatic run_word(input logic [31:0] w, input int mode, input bit inject);
    logic q[$];
    int   idx, stalls, cyc, waited;
    bit   rdy, finished;
    for (int i = 31; i >= 0; i--) q.push_back(w[i]);
`ifdef SERIALIZER_PARITY_EN
    q.push_back(^w);
`endif
    waited = 0;
    while (!load_ready_o && waited < 10) begin
      @(negedge clk_i);
      waited++;
    end
    chk("load_ready_wait", 32'(load_ready_o), 32'd1);
    load_valid_i = 1'b1;
    data_in_i    = w;
    ser_ready_i  = $urandom_range(0, 1) == 1;
    @(negedge clk_i);
    load_valid_i = 1'b0;
    data_in_i    = $urandom;
    idx = 0; stalls = 0; cyc = 1; finished = 0;
    while (!finished && cyc < 400) begin
      if (idx < q.size()) begin
        chk("ser_valid",  32'(ser_valid_o),  32'd1);
        chk("ser_out",    32'(ser_out_o),    32'(q[idx]));
        chk("busy",       32'(busy_o),       32'd1);
        chk("load_ready", 32'(load_ready_o), 32'd0);
        chk("done_early", 32'(done_o),       32'd0);
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = (cyc % 2) == 1;
          default: rdy = $urandom_range(0, 1) == 1;
        endcase
        ser_ready_i = rdy;
        if (inject && $urandom_range(0, 3) == 0) begin
          load_valid_i = 1'b1;
          data_in_i    = $urandom;
        end else begin
          load_valid_i = 1'b0;
        end
        if (rdy) idx++;
        else stalls++;
      end else begin
        chk("done",       32'(done_o),      32'd1);
        chk("fin_valid",  32'(ser_valid_o), 32'd0);
        chk("fin_out",    32'(ser_out_o),   32'd0);
        chk("fin_busy",   32'(busy_o),      32'd1);
        chk("done_cycle", 32'(cyc),         32'(q.size() + stalls + 1));
        load_valid_i = 1'b0;
        ser_ready_i  = $urandom_range(0, 1) == 1;
        finished = 1;
      end
      @(negedge clk_i);
      cyc++;
    end
    if (!finished) chk("timeout", 32'd0, 32'd1);
    chk_idle_outputs("post");
  endtask

  initial begin
    logic [31:0] w;
    #2;
    chk_idle_outputs("in_reset");
    #10 rst_ni = 1'b1;
    @(negedge clk_i);
    chk_idle_outputs("reset");

    run_word(32'hA5A5_0001, 0, 1'b0);
    run_word(32'h8000_0000, 1, 1'b0);
    run_word(32'h0000_00FF, 0, 1'b1);

    // reset after 10 accepted bits of DEADBEEF
    w = 32'hDEAD_BEEF;
    load_valid_i = 1'b1;
    data_in_i    = w;
    ser_ready_i  = 1'b1;
    @(negedge clk_i);
    load_valid_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("pre_reset_bit", 32'(ser_out_o), 32'(w[31 - i]));
      @(negedge clk_i);
    end
    #2 rst_ni = 1'b0;
    #1 chk_idle_outputs("async_reset");
    @(negedge clk_i);
    chk_idle_outputs("held_reset");
    #2 rst_ni = 1'b1;
    @(negedge clk_i);
    chk_idle_outputs("after_reset");

    run_word(32'h1234_5678, 0, 1'b0);
    run_word(32'h0000_0007, 0, 1'b0);
    run_word(32'h0000_0003, 0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      w = $urandom;
      run_word(w, 2, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg32_serializer.md
Name: reg32_serializer

Overview:
- Parallel-to-serial transmitter that reads out a 32-bit register word.
- Accepts a word on a valid/ready load handshake, then shifts it out one bit per accepted serial beat, MSB first.
- Sits downstream of the 32-bit enable register: that register's Data_out feeds this block's Data_in.
- Its counterpart is a serial-to-parallel receiver that rebuilds the word on the far side.

Parameters:
- WIDTH, 32, word width in bits; must be at least 2.
- CNT_W, 6, bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- Clock  input  1  rising-edge system clock.
- Reset  input  1  asynchronous, active-low reset.
- Load_valid  input  1  Data_in holds a word to send.
- Load_ready  output  1  block can accept a word this cycle.
- Data_in  input  WIDTH  parallel word to transmit.
- Ser_ready  input  1  sink accepts the current serial bit at this edge.
- Ser_valid  output  1  Ser_out carries a valid bit.
- Ser_out  output  1  serial data bit.
- Busy  output  1  a transfer is in progress.
- Done  output  1  one-cycle pulse after the final bit is accepted.

Behaviour:
- Reset (asynchronous, Reset=0):
  - state=IDLE, shift register=0, count=0.
  - Outputs: Load_ready=1, Ser_valid=0, Ser_out=0, Busy=0, Done=0.
- States: IDLE, SHIFT, FIN (plus PAR when the optional feature is compiled in).
- IDLE:
  - Load_ready=1, Busy=0.
  - On a rising edge with Load_valid=1: capture Data_in into shreg, count=0, go to SHIFT.
- SHIFT:
  - Ser_valid=1, Busy=1, Load_ready=0.
  - Ser_out=shreg[WIDTH-1] (decoded combinationally from registers; no input-to-output combinational path).
  - On an edge with Ser_ready=1: shreg shifts left, zero-filled; count increments.
  - If count==WIDTH-1 at that edge: go to FIN.
  - On an edge with Ser_ready=0: shreg, count and state hold, so Ser_out stays stable (stall).
- FIN:
  - Done=1, Busy=1, Ser_valid=0, Load_ready=0, for exactly one cycle.
  - Then go to IDLE.
- Ser_out=0 whenever Ser_valid=0.
- Latency with Ser_ready held high:
  - Load accepted at edge k.
  - Bit i is presented in the cycle after edge k+i.
  - Done is high in the cycle after edge k+WIDTH.
  - Load_ready returns to 1 after edge k+WIDTH+1.
  - Back-to-back word period is WIDTH+2 cycles.
- Load_valid is ignored while Load_ready=0; Data_in may change freely after capture.
- Reset asserted mid-transfer: the partial word is discarded and all outputs return to their reset values immediately. No Done pulse is produced.
- Ser_ready has no effect in IDLE or FIN.
- Counter never wraps: it is cleared on load and stops at WIDTH-1.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- Defined:
  - After the last data bit is accepted, go to PAR instead of FIN.
  - PAR presents an even-parity bit, Ser_out = ^word, computed and registered at load, with Ser_valid=1.
  - The parity bit obeys the same Ser_ready stall rule; its acceptance moves the block to FIN.
  - Word period becomes WIDTH+3 cycles.
- Undefined: no PAR state and no parity register; behaviour exactly as above.

Decomposition:
- Package reg32_ser_pkg holds:
  - state encoding typedef: IDLE=2'd0, SHIFT=2'd1, FIN=2'd2, PAR=2'd3;
  - default WIDTH and CNT_W constants.
- One natural sub-module, ser_bit_counter: a clearable, enabled up-counter with a terminal-count flag at WIDTH-1.
- Shift register and FSM stay in the top level.

Test Plan:
- Reset=0 at t=0, release at 12: all outputs at reset values; Load_ready=1.
- Load 32'hA5A5_0001, Ser_ready=1:
  - bits 1,0,1,0,0,1,0,1 appear first; the 32nd bit is 1;
  - Done high exactly one cycle, 33 cycles after the accept edge;
  - Load_ready=1 again the next cycle.
- Load 32'h8000_0000, Ser_ready toggling 1/0 each cycle: Ser_out holds 1 through stalls; 64 cycles to Done; the remaining 31 bits are 0.
- Load 32'h0000_00FF, pulse Load_valid with 32'hFFFF_FFFF mid-transfer: the second word is ignored; output stream equals 24 zeros then 8 ones.
- Reset pulsed low after 10 accepted bits of 32'hDEAD_BEEF: outputs clear immediately, no Done; a following load of 32'h1234_5678 transmits correctly.
- With SERIALIZER_PARITY_EN, load 32'h0000_0007: 33rd bit = 1, Done 34 cycles after accept. With 32'h0000_0003: 33rd bit = 0.
